uart_program_loader: RTL

Receives the 8N1 serial byte stream on UART_RX at CLKS_PER_BIT clocks per bit and assembles each group of four bytes into a 32-bit instruction word, first byte in bits 31:24. Each word is emitted with an auto-incrementing word address, ready to be written into instruction memory. Sits between the UART_RX pin and the CPU's instruction-memory write port and is active during the program-load phase. Raw bytes are also exposed for the data-input path.

---
 rtl/uart_program_loader_if.sv | 40 ++++
 rtl/uart_program_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader_if.sv
// Purpose : bundles the loader's serial input, control inputs and byte/word outputs.
// Latency : n/a (signal bundle only).
// Backpr. : none; WORD_VALID is a write strobe that must be taken when asserted.
//
// Ports (as seen from the loader, modport slave):
//   UART_RX    in   serial line, idle high, asynchronous to CLK
//   ENABLE     in   1 = assemble words, 0 = bytes only (partial word dropped)
//   CLEAR      in   one-cycle pulse: address, byte count and ERR back to 0
//   BYTE_VALID out  one-cycle pulse per good byte
//   BYTE_DATA  out  last good byte, held
//   WORD_VALID out  one-cycle instruction-memory write strobe
//   WORD_DATA  out  assembled word, first byte in [31:24], held
//   WORD_ADDR  out  word address for WORD_DATA
//   FRAME_ERR  out  one-cycle pulse on a bad stop bit
//   ERR        out  sticky framing-error flag
// The master modport is the opposite side (line driver / consumer).
interface uart_program_loader_if #(
   parameter int ADDR_W = 14
) ();
   logic              UART_RX;
   logic              ENABLE;
   logic              CLEAR;
   logic              BYTE_VALID;
   logic [7:0]        BYTE_DATA;
   logic              WORD_VALID;
   logic [31:0]       WORD_DATA;
   logic [ADDR_W-1:0] WORD_ADDR;
   logic              FRAME_ERR;
   logic              ERR;

   modport master (
      output UART_RX, ENABLE, CLEAR,
      input  BYTE_VALID, BYTE_DATA, WORD_VALID, WORD_DATA, WORD_ADDR, FRAME_ERR, ERR
   );

   modport slave (
      input  UART_RX, ENABLE, CLEAR,
      output BYTE_VALID, BYTE_DATA, WORD_VALID, WORD_DATA, WORD_ADDR, FRAME_ERR, ERR
   );
endinterface

// File: rtl/uart_program_loader.sv
// Purpose : 8N1 UART receiver that packs every four good bytes into a 32-bit
//           instruction word (first byte in [31:24]) with an auto-incrementing address.
// Latency : BYTE_VALID/FRAME_ERR 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after
//           the start-bit edge at the pin; WORD_VALID one cycle after the 4th BYTE_VALID.
// Backpr. : none; the memory write port must accept WORD_VALID in the cycle it is high.
//
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset
//   bus  uart_program_loader_if.slave (UART_RX/ENABLE/CLEAR in, byte/word/error out)
// CLKS_PER_BIT must be at least 4 so the half-bit and full-bit counts are distinct.
module uart_program_loader #(
   parameter int CLKS_PER_BIT = 2604,
   parameter int ADDR_W       = 14
) (
   input  logic                  CLK,
   input  logic                  RST,
   uart_program_loader_if.slave  bus
);

   localparam int               CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } rx_state_t;

   // ------------------------------------------------------------------
   // Two-flop synchronizer; reset to the idle-high line level so that
   // leaving reset never looks like a start bit.
   // ------------------------------------------------------------------
   logic rx_meta;
   logic rx_s;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.UART_RX;
         rx_s    <= rx_meta;
      end
   end

   // ------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------
   rx_state_t        state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [2:0]       bit_q,      bit_d;
   logic [7:0]       shift_q,    shift_d;
   logic             byte_vld_q, byte_vld_d;
   logic [7:0]       byte_dat_q, byte_dat_d;
   logic             ferr_q,     ferr_d;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_vld_q <= 1'b0;
         byte_dat_q <= '0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_vld_q <= byte_vld_d;
         byte_dat_q <= byte_dat_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_vld_d = 1'b0;
      byte_dat_d = byte_dat_q;
      ferr_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rx_s) begin
               state_d = S_START;
            end
         end

         // Re-check the line at the middle of the start bit; a high line
         // there means the falling edge was a glitch.
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // From the start-bit midpoint, each full bit period lands on the
         // middle of the next bit. LSB arrives first.
         S_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Leaving at the stop-bit midpoint leaves half a bit of slack so
         // a start bit directly after the stop bit is not missed.
         S_STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  byte_vld_d = 1'b1;
                  byte_dat_d = shift_q;
                  state_d    = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // A line held low (break) reports one error, then waits for idle.
         S_BREAK: begin
            cnt_d = '0;
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Word assembler, address counter and sticky error.
   // Runs one cycle behind the receiver, off the registered byte strobe,
   // so WORD_VALID lands the cycle after the 4th BYTE_VALID.
   // ------------------------------------------------------------------
   logic [1:0]        byte_cnt_q;
   logic [23:0]       acc_q;
   logic              word_vld_q;
   logic [31:0]       word_dat_q;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;
   logic              drop_partial;

   // Any of these abandons the word in progress; a 4th byte completing
   // in the same cycle is still emitted since its data is already complete.
   assign drop_partial = !bus.ENABLE || ferr_q || bus.CLEAR;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         byte_cnt_q <= '0;
         acc_q      <= '0;
         word_vld_q <= 1'b0;
         word_dat_q <= '0;
         addr_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         word_vld_q <= 1'b0;

         if (bus.ENABLE && byte_vld_q) begin
            if (byte_cnt_q == 2'd3) begin
               word_vld_q <= 1'b1;
               word_dat_q <= {acc_q, byte_dat_q};
               byte_cnt_q <= '0;
            end else begin
               acc_q      <= {acc_q[15:0], byte_dat_q};
               byte_cnt_q <= byte_cnt_q + 2'd1;
            end
         end

         if (drop_partial) begin
            byte_cnt_q <= '0;
            acc_q      <= '0;
         end

         // The address moves only after the strobe cycle, so it stays stable
         // while WORD_VALID is high; CLEAR in that cycle still wins afterwards.
         if (bus.CLEAR) begin
            addr_q <= '0;
         end else if (word_vld_q) begin
            addr_q <= addr_q + 1'b1;
         end

         // ERR rises together with FRAME_ERR; CLEAR beats a coincident error.
         if (bus.CLEAR) begin
            err_q <= 1'b0;
         end else if (ferr_d) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.BYTE_VALID = byte_vld_q;
   assign bus.BYTE_DATA  = byte_dat_q;
   assign bus.WORD_VALID = word_vld_q;
   assign bus.WORD_DATA  = word_dat_q;
   assign bus.WORD_ADDR  = addr_q;
   assign bus.FRAME_ERR  = ferr_q;
   assign bus.ERR        = err_q;

endmodule
